// File: rtl/fifo_rr_write_arbiter_if.sv
// Bundle of producer handshake and FIFO-side signals for the round-robin
// write arbiter. The arbiter uses the master view. The producers and the FIFO
// model use the slave view.
interface fifo_rr_write_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int BITS      = 12,
    parameter int CNT_WIDTH = 4
);
    logic [N_REQ-1:0]      req;
    logic [N_REQ*BITS-1:0] req_data;
    logic [N_REQ-1:0]      gnt;
    logic                  fifo_write;
    logic [BITS-1:0]       fifo_data;
    logic                  fifo_read;
    logic                  fifo_ready;
    logic                  fifo_ovf;
    logic [CNT_WIDTH-1:0]  level;
    logic                  full;
    logic                  ovf_err;

    modport master (
        input  req, req_data, fifo_read, fifo_ready, fifo_ovf,
        output gnt, fifo_write, fifo_data, level, full, ovf_err
    );

    modport slave (
        output req, req_data, fifo_read, fifo_ready, fifo_ovf,
        input  gnt, fifo_write, fifo_data, level, full, ovf_err
    );
endinterface

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin write arbiter in front of a FIFO (mySRAM).
// A credit counter tracks FIFO occupancy, so the FIFO is never written when it
// is full. Each producer may own the port for up to BURST consecutive words.
module fifo_rr_write_arbiter #(
    parameter int N_REQ      = 4,
    parameter int BITS       = 12,
    parameter int WORD_DEPTH = 8,
    parameter int CNT_WIDTH  = 4,
    parameter int BURST      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fifo_rr_write_arbiter_if.master bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BC_W  = $clog2(BURST + 1);
    localparam logic [CNT_WIDTH-1:0] CAP = CNT_WIDTH'(WORD_DEPTH - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t               state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     owner;
    logic [BC_W-1:0]      burst_cnt;
    logic [BC_W-1:0]      burst_next;
    logic [CNT_WIDTH-1:0] level_q;
    logic [BITS-1:0]      data_q;
    logic                 write_q;
    logic                 ovf_q;

    logic [PTR_W-1:0]     sel_idx;
    logic                 found;
    logic [PTR_W-1:0]     grant_idx;
    logic [N_REQ-1:0]     gnt_c;
    logic                 accept;
    logic                 pop;
    logic                 full_c;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        if (i == PTR_W'(N_REQ - 1)) begin
            return '0;
        end
        return i + PTR_W'(1);
    endfunction

    assign full_c     = (level_q == CAP);
    assign pop        = bus.fifo_read && bus.fifo_ready && (level_q != '0);
    assign burst_next = burst_cnt + BC_W'(1);
    assign grant_idx  = (state == OWN) ? owner : sel_idx;
    assign accept     = |(bus.req & gnt_c);

    // Find the first active requester, scanning upward from rr_ptr with wrap-around.
    always_comb begin
        int               j;
        logic [PTR_W-1:0] jj;
        found   = 1'b0;
        sel_idx = '0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            jj = PTR_W'(j);
            if (!found && bus.req[jj]) begin
                found   = 1'b1;
                sel_idx = jj;
            end
        end
    end

    // Grant vector. It is held at zero in reset and while the credits are exhausted.
    always_comb begin
        gnt_c = '0;
        if (rst_n && !full_c) begin
            case (state)
                IDLE: if (found) gnt_c[sel_idx] = 1'b1;
                OWN:  if (bus.req[owner]) gnt_c[owner] = 1'b1;
                default: gnt_c = '0;
            endcase
        end
    end

    // Arbitration FSM. In OWN state, any cycle that does not accept a word hands the port back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner     <= sel_idx;
                        burst_cnt <= BC_W'(1);
                        if (BURST > 1) begin
                            state <= OWN;
                        end else begin
                            rr_ptr <= next_idx(sel_idx);
                        end
                    end
                end
                OWN: begin
                    if (accept && (burst_next != BC_W'(BURST))) begin
                        burst_cnt <= burst_next;
                    end else begin
                        if (accept) begin
                            burst_cnt <= burst_next;
                        end
                        state  <= IDLE;
                        rr_ptr <= next_idx(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register the accepted word toward the FIFO. The data holds its value when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            data_q  <= '0;
        end else begin
            write_q <= accept;
            if (accept) begin
                data_q <= bus.req_data[grant_idx*BITS +: BITS];
            end
        end
    end

    // Credit counter. An acceptance and a pop in the same cycle cancel each other out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else if (accept && !pop) begin
            level_q <= level_q + CNT_WIDTH'(1);
        end else if (!accept && pop) begin
            level_q <= level_q - CNT_WIDTH'(1);
        end
    end

    // Sticky overflow flag. A FIFO overflow means the credit model has a bug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.fifo_ovf) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.gnt        = gnt_c;
    assign bus.fifo_write = write_q;
    assign bus.fifo_data  = data_q;
    assign bus.level      = level_q;
    assign bus.full       = full_c;
    assign bus.ovf_err    = ovf_q;
endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Directed testbench for fifo_rr_write_arbiter. The expected values are
// worked out by hand for N_REQ=4, BURST=4 and CAP=7.
module tb_fifo_rr_write_arbiter;
    localparam int N_REQ = 4;
    localparam int BITS  = 12;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fifo_rr_write_arbiter_if #(.N_REQ(N_REQ), .BITS(BITS), .CNT_WIDTH(CW)) bus ();

    fifo_rr_write_arbiter #(
        .N_REQ(N_REQ), .BITS(BITS), .WORD_DEPTH(8), .CNT_WIDTH(CW), .BURST(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic clear_inputs();
        bus.req        = '0;
        bus.req_data   = {12'h103, 12'h102, 12'h101, 12'h100};
        bus.fifo_read  = 1'b0;
        bus.fifo_ready = 1'b0;
        bus.fifo_ovf   = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.req = 4'b1111;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.fifo_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %b expected 0", bus.fifo_write); end
        checks++; if (bus.fifo_data !== 12'h000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 000", bus.fifo_data); end
        checks++; if (bus.level !== 4'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", bus.level); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", bus.full); end
        checks++; if (bus.ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf_err: got %b expected 0", bus.ovf_err); end
        rst_n = 1'b1;
    endtask

    // All four producers request. Owner 0 bursts 4 words, then owner 1 takes 3 and the credits run out.
    task automatic test_fill();
        logic [3:0]  exp_g [0:6];
        logic [11:0] exp_d [0:6];
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
        exp_d = '{12'h100, 12'h100, 12'h100, 12'h100, 12'h101, 12'h101, 12'h101};
        bus.req = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            #1;
            checks++; if (bus.gnt !== exp_g[c]) begin errors++; $display("[TB] FAIL fill_gnt[%0d]: got %b expected %b", c, bus.gnt, exp_g[c]); end
            checks++; if (bus.level !== CW'(c)) begin errors++; $display("[TB] FAIL fill_level[%0d]: got %0d expected %0d", c, bus.level, c); end
            @(negedge clk);
            checks++; if (bus.fifo_write !== 1'b1 || bus.fifo_data !== exp_d[c]) begin errors++; $display("[TB] FAIL fill_out[%0d]: got write=%b data=%h expected write=1 data=%h", c, bus.fifo_write, bus.fifo_data, exp_d[c]); end
        end
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL full_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.level !== 4'd7 || bus.full !== 1'b1) begin errors++; $display("[TB] FAIL full_level: got level=%0d full=%b expected level=7 full=1", bus.level, bus.full); end
        @(negedge clk);
        checks++; if (bus.fifo_write !== 1'b0) begin errors++; $display("[TB] FAIL full_write: got %b expected 0", bus.fifo_write); end
    endtask

    // One pop at full frees one credit, which goes to the next requester in round-robin order (producer 2).
    task automatic test_full_pop();
        bus.fifo_read  = 1'b1;
        bus.fifo_ready = 1'b1;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL pop_cycle_gnt: got %b expected 0000", bus.gnt); end
        @(negedge clk);
        bus.fifo_read  = 1'b0;
        bus.fifo_ready = 1'b0;
        checks++; if (bus.level !== 4'd6 || bus.full !== 1'b0) begin errors++; $display("[TB] FAIL pop_level: got level=%0d full=%b expected level=6 full=0", bus.level, bus.full); end
        #1;
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("[TB] FAIL pop_gnt: got %b expected 0100", bus.gnt); end
        @(negedge clk);
        checks++; if (bus.level !== 4'd7) begin errors++; $display("[TB] FAIL pop_refill_level: got %0d expected 7", bus.level); end
        checks++; if (bus.fifo_write !== 1'b1 || bus.fifo_data !== 12'h102) begin errors++; $display("[TB] FAIL pop_refill_out: got write=%b data=%h expected write=1 data=102", bus.fifo_write, bus.fifo_data); end
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL pop_after_gnt: got %b expected 0000", bus.gnt); end
        @(negedge clk);
        checks++; if (bus.ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL pop_ovf_err: got %b expected 0", bus.ovf_err); end
        bus.req = '0;
    endtask

    // A single requester is granted in the same cycle and its word appears on the FIFO side one cycle later.
    task automatic test_single();
        reset_dut();
        bus.req      = 4'b0100;
        bus.req_data = {12'h103, 12'hABC, 12'h101, 12'h100};
        #1;
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("[TB] FAIL single_gnt: got %b expected 0100", bus.gnt); end
        @(negedge clk);
        bus.req = '0;
        checks++; if (bus.fifo_write !== 1'b1 || bus.fifo_data !== 12'hABC) begin errors++; $display("[TB] FAIL single_out: got write=%b data=%h expected write=1 data=ABC", bus.fifo_write, bus.fifo_data); end
        checks++; if (bus.level !== 4'd1) begin errors++; $display("[TB] FAIL single_level: got %0d expected 1", bus.level); end
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL single_drop_gnt: got %b expected 0000", bus.gnt); end
        @(negedge clk);
        checks++; if (bus.fifo_write !== 1'b0 || bus.fifo_data !== 12'hABC) begin errors++; $display("[TB] FAIL single_hold: got write=%b data=%h expected write=0 data=ABC", bus.fifo_write, bus.fifo_data); end
    endtask

    // Owner 0 drops its request after 2 words. Producer 3 is granted only after the exit cycle.
    task automatic test_owner_drop();
        reset_dut();
        bus.req = 4'b1001;
        #1;
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL drop_gnt0: got %b expected 0001", bus.gnt); end
        @(negedge clk);
        #1;
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("[TB] FAIL drop_gnt1: got %b expected 0001", bus.gnt); end
        @(negedge clk);
        bus.req = 4'b1000;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("[TB] FAIL drop_gnt2: got %b expected 0000", bus.gnt); end
        @(negedge clk);
        #1;
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("[TB] FAIL drop_gnt3: got %b expected 1000", bus.gnt); end
        @(negedge clk);
        bus.req = '0;
        checks++; if (bus.level !== 4'd3 || bus.fifo_data !== 12'h103) begin errors++; $display("[TB] FAIL drop_end: got level=%0d data=%h expected level=3 data=103", bus.level, bus.fifo_data); end
        @(negedge clk);
    endtask

    // An acceptance and a pop in the same cycle at level 3 leave the level at 3.
    task automatic test_accept_and_pop();
        bus.req        = 4'b0010;
        bus.fifo_read  = 1'b1;
        bus.fifo_ready = 1'b1;
        #1;
        checks++; if (bus.gnt !== 4'b0010 || bus.level !== 4'd3) begin errors++; $display("[TB] FAIL ap_pre: got gnt=%b level=%0d expected gnt=0010 level=3", bus.gnt, bus.level); end
        @(negedge clk);
        bus.req        = '0;
        bus.fifo_read  = 1'b0;
        bus.fifo_ready = 1'b0;
        checks++; if (bus.level !== 4'd3) begin errors++; $display("[TB] FAIL ap_level: got %0d expected 3", bus.level); end
        checks++; if (bus.fifo_write !== 1'b1 || bus.fifo_data !== 12'h101) begin errors++; $display("[TB] FAIL ap_out: got write=%b data=%h expected write=1 data=101", bus.fifo_write, bus.fifo_data); end
        @(negedge clk);
        checks++; if (bus.fifo_write !== 1'b0 || bus.level !== 4'd3) begin errors++; $display("[TB] FAIL ap_after: got write=%b level=%0d expected write=0 level=3", bus.fifo_write, bus.level); end
    endtask

    // The overflow flag is sticky. An asynchronous reset mid-burst clears every output at once.
    task automatic test_ovf_and_async_reset();
        bus.fifo_ovf = 1'b1;
        @(negedge clk);
        bus.fifo_ovf = 1'b0;
        checks++; if (bus.ovf_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", bus.ovf_err); end
        @(negedge clk);
        checks++; if (bus.ovf_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", bus.ovf_err); end
        bus.req = 4'b1111;
        #1;
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("[TB] FAIL burst_gnt: got %b expected 0100", bus.gnt); end
        @(negedge clk);
        checks++; if (bus.fifo_write !== 1'b1 || bus.level !== 4'd4) begin errors++; $display("[TB] FAIL burst_out: got write=%b level=%0d expected write=1 level=4", bus.fifo_write, bus.level); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.gnt !== 4'b0000 || bus.fifo_write !== 1'b0 || bus.fifo_data !== 12'h000) begin errors++; $display("[TB] FAIL async_rst_a: got gnt=%b write=%b data=%h expected 0000 0 000", bus.gnt, bus.fifo_write, bus.fifo_data); end
        checks++; if (bus.level !== 4'd0 || bus.full !== 1'b0 || bus.ovf_err !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_b: got level=%0d full=%b ovf_err=%b expected 0 0 0", bus.level, bus.full, bus.ovf_err); end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        $display("[TB] starting fifo_rr_write_arbiter directed tests");
        test_reset();
        test_fill();
        test_full_pop();
        test_single();
        test_owner_drop();
        test_accept_and_pop();
        test_ovf_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
